// File: rtl/fpadd_pkg.sv
// Shared constants and types for the floating-point adder result path.
// Holds the result-type codes, canonical IEEE-754 double encodings and flag bit positions.
package fpadd_pkg;

  typedef enum logic [3:0] {
    ZT_NORMAL = 4'b0000,
    ZT_QNAN   = 4'b0001,
    ZT_NINF   = 4'b0010,
    ZT_PINF   = 4'b0011,
    ZT_PZERO  = 4'b0100,
    ZT_MZERO  = 4'b0101,
    ZT_NZERO  = 4'b0110,
    ZT_CVT    = 4'b1000
  } ztype_e;

  localparam logic [63:0] QNAN64  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF64  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF64  = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] NZERO64 = 64'h8000_0000_0000_0000;

  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  localparam logic [2:0] RM_RDN = 3'b010;

endpackage

// File: rtl/fpadd_special_decode.sv
// Combinational mapping from result-type code to the final double result and its flags.
// Codes outside the defined set collapse to the canonical qNaN with invalid raised.
module fpadd_special_decode
  import fpadd_pkg::*;
(
  input  logic [3:0]  Ztype,
  input  logic        Invalid,
  input  logic [2:0]  Frm,
  input  logic [63:0] NormResult,
  input  logic [2:0]  NormFlags,
  output logic [63:0] result,
  output logic [4:0]  flags
);

  always_comb begin
    result = NormResult;
    flags  = '0;
    case (Ztype)
      ZT_NORMAL, ZT_CVT: flags = {2'b00, NormFlags};
      ZT_QNAN: begin
        result    = QNAN64;
        flags[NV] = Invalid;
      end
      ZT_NINF:  result = NINF64;
      ZT_PINF:  result = PINF64;
      ZT_PZERO: result = '0;
      ZT_NZERO: result = NZERO64;
      // Exact cancellation of opposite-signed zeros is -0 only when rounding down
      ZT_MZERO: result = (Frm == RM_RDN) ? NZERO64 : '0;
      default: begin
        result    = QNAN64;
        flags[NV] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fpadd_result_encoder.sv
// Output stage of the FP adder: decode, two-stage valid/ready pipeline and sticky fflags.
// S1 holds the decoded value, S2 drives Result/Flags; no skid buffer, so InReady sees OutReady.
module fpadd_result_encoder
  import fpadd_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [3:0]      Ztype,
  input  logic            Invalid,
  input  logic [2:0]      Frm,
  input  logic [XLEN-1:0] NormResult,
  input  logic [2:0]      NormFlags,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      Flags,
  output logic [4:0]      FFlags,
  input  logic            FlagsWrEn,
  input  logic [4:0]      FlagsWrData
);

  logic [XLEN-1:0] dec_result;
  logic [4:0]      dec_flags;

  logic            s1_valid;
  logic [XLEN-1:0] s1_result;
  logic [4:0]      s1_flags;
  logic            s2_valid;
  logic            s2_load;
  logic            accept;
  logic            retire;

  fpadd_special_decode u_decode (
    .Ztype      (Ztype),
    .Invalid    (Invalid),
    .Frm        (Frm),
    .NormResult (NormResult),
    .NormFlags  (NormFlags),
    .result     (dec_result),
    .flags      (dec_flags)
  );

  assign s2_load  = ~s2_valid | OutReady;
  assign InReady  = ~s1_valid | s2_load;
  assign accept   = InValid & InReady & ~Flush;
  assign retire   = s2_valid & OutReady & ~Flush;
  assign OutValid = s2_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_flags  <= '0;
    end else begin
      if (Flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (accept) begin
        s1_result <= dec_result;
        s1_flags  <= dec_flags;
      end
    end
  end

  // Data only moves on a real advance so Result/Flags stay frozen under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      Result   <= '0;
      Flags    <= '0;
    end else begin
      if (Flush)        s2_valid <= 1'b0;
      else if (s2_load) s2_valid <= s1_valid;
      if (!Flush && s2_load && s1_valid) begin
        Result <= s1_result;
        Flags  <= s1_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          FFlags <= '0;
    else if (FlagsWrEn) FFlags <= FlagsWrData | (retire ? Flags : 5'b0);
    else if (retire)    FFlags <= FFlags | Flags;
  end

endmodule

// File: doc/fpadd_result_encoder.md
# fpadd_result_encoder

Output stage of the floating-point adder, the inverse of the operand classifier: it takes the 4-bit result-type code (Ztype) and exception indications produced during classification, plus the normal-path datapath result. It builds the final IEEE-754 double result and per-operation flags through a 2-stage valid/ready pipeline, and accumulates sticky fflags for the CSR file.

## Interface
Parameters:
- XLEN, 64, result width (double precision only)

Ports:
- clk  in  1  clock; all state rising-edge
- reset  in  1  asynchronous, active-high
- InValid  in  1  upstream operation valid
- InReady  out  1  encoder can accept this cycle
- Ztype  in  4  result type: 0000 normal, 0001 qNaN, 0010 −Inf, 0011 +Inf, 0100 +0, 0101 mixed-sign zeros, 0110 −0, 1000 convert
- Invalid  in  1  invalid-operation indication
- Frm  in  3  rounding mode (010 = RDN)
- NormResult  in  64  datapath result (used for 0000/1000)
- NormFlags  in  3  {OF,UF,NX} from datapath rounding
- Flush  in  1  kill all in-flight operations
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts
- Result  out  64  final result
- Flags  out  5  {NV,DZ,OF,UF,NX} for this result
- FFlags  out  5  sticky accumulated flags
- FlagsWrEn  in  1  CSR write strobe
- FlagsWrData  in  5  CSR write value

## Operation
- Decode (combinational, from inputs):
  - 0000, 1000 → NormResult; flags {0,0,NormFlags}.
  - 0001 → 64'h7FF8_0000_0000_0000; NV = Invalid.
  - 0010 → 64'hFFF0_0000_0000_0000; 0011 → 64'h7FF0_0000_0000_0000; flags 0.
  - 0100 → 64'h0; 0110 → 64'h8000_0000_0000_0000.
  - 0101 → 64'h8000_0000_0000_0000 if Frm==010, else 64'h0; flags 0.
  - Any other code → canonical qNaN, NV=1.
- DZ is always 0.
- Pipeline:
  - S1 holds the decoded result/flags; S2 is the output register.
  - S2 loads when empty or OutReady.
  - S1 advances into S2 when S1 is valid and S2 loads.
  - S1 accepts when InValid & InReady.
- InReady = ~S1Valid | S2Load. This is combinational from OutReady; no skid buffer.
- Data registers hold their value while stalled. Result and Flags must stay stable while OutValid & ~OutReady.
- Sticky accumulation:
  - On retire (OutValid & OutReady & ~Flush): FFlags |= Flags.
  - FlagsWrEn: FFlags ← FlagsWrData | (retiring Flags, if a retire occurs the same cycle).
- Flush:
  - Clears S1Valid and S2Valid next edge.
  - No retire is counted that cycle. An input presented that cycle is dropped.
  - FFlags is changed only by FlagsWrEn.

## Timing
- Reset values:
  - S1Valid, S2Valid, OutValid = 0.
  - Result = 64'h0, Flags = 0, FFlags = 0.
  - InReady = 1 combinationally once out of reset.
- Latency: accept at edge N → OutValid high after edge N+1 (second register); Result visible the cycle after S1 capture.
- Throughput: 1 op/cycle with OutReady held high.
- Full: both stages valid and ~OutReady → InReady = 0.
- Simultaneous accept + retire with both stages full: all advance; no loss.
- Reset mid-operation: pipeline empties immediately (async); FFlags cleared.

## Structure
- Shared package `fpadd_pkg`:
  - Ztype code constants (ZT_NORMAL, ZT_QNAN, ZT_NINF, ZT_PINF, ZT_PZERO, ZT_MZERO, ZT_NZERO, ZT_CVT).
  - Canonical constants QNAN64, PINF64, NINF64, NZERO64.
  - Flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - RM_RDN = 3'b010.
- One combinational sub-module `fpadd_special_decode` (Ztype, Invalid, Frm, NormResult, NormFlags → result, flags).
- Pipeline, handshake and sticky logic stay in the top.

## Test plan
- Reset asserted mid-stream with both stages full → OutValid=0, FFlags=0, InReady=1 immediately.
- Ztype=0001, Invalid=1, OutReady=1 → Result=64'h7FF8_0000_0000_0000, Flags=5'b10000 two cycles later; FFlags=5'b10000 after retire.
- Ztype=0101 with Frm=010, then Frm=000 → Results 64'h8000_0000_0000_0000 then 64'h0, back-to-back at 1/cycle.
- Stream 4 ops with OutReady low for 3 cycles → after 2 accepts InReady=0; Result held stable; all 4 emerge in order after release, none lost or duplicated.
- Ztype=0000, NormFlags=3'b001 retiring in the same cycle as FlagsWrEn=1, FlagsWrData=5'b00100 → FFlags=5'b00101.
- Flush with S1 and S2 valid and Ztype=0001 in S2 → no OutValid afterward; FFlags unchanged.
